// File: rtl/spi_pkg.sv
// Shared definitions for the arbitrated SPI master: FSM encoding and default geometry.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_TRAIL = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int DEF_NBITS   = 8;
  localparam int DEF_CLK_DIV = 4;

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin arbiter; the last-owner pointer starts out favouring requester 0.
module spi_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       owner,
  output logic [1:0] grant
);

  logic last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (update) begin
      last <= owner;
    end
  end

  // A lone requester always wins; on a tie the one that did not go last wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/spi_master_arb.sv
// SPI master (mode 0, active-high CS) shared by two requesters through a round-robin arbiter.
module spi_master_arb
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int NBITS   = DEF_NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [NBITS-1:0] tx_data0,
  input  logic [NBITS-1:0] tx_data1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [NBITS-1:0] rx_data,
  output logic             busy,
  output logic             SLK,
  output logic             CS,
  output logic             MOSI,
  input  logic             MISO,
  output state_t           state
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS);

  // Handshake: req is a level held until its gnt pulse; gnt means the word on
  // tx_dataN was taken, and the matching done pulse carries rx_data back.
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_cnt;
  logic [NBITS-1:0] shift;
  logic [NBITS-1:0] rx_shift;
  logic             owner;
  logic [1:0]       grant;
  logic [NBITS-1:0] tx_sel;
  logic [NBITS-1:0] shift_next;
  logic [NBITS-1:0] rx_next;

  spi_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (state == S_DONE),
    .owner  (owner),
    .grant  (grant)
  );

  always_comb begin
    tx_sel     = grant[1] ? tx_data1 : tx_data0;
    shift_next = shift << 1;
    rx_next    = rx_shift << 1;
    rx_next[0] = MISO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      rx_shift <= '0;
      owner    <= 1'b0;
      gnt      <= 2'b00;
      done     <= 2'b00;
      busy     <= 1'b0;
      rx_data  <= '0;
      SLK      <= 1'b0;
      CS       <= 1'b0;
      MOSI     <= 1'b0;
    end else begin
      gnt  <= 2'b00;
      done <= 2'b00;
      case (state)
        S_IDLE: begin
          if (|req) begin
            gnt     <= grant;
            owner   <= grant[1];
            shift   <= tx_sel;
            MOSI    <= tx_sel[NBITS-1];
            CS      <= 1'b1;
            busy    <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            state   <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            SLK   <= 1'b1;
            state <= S_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_HIGH: begin
          // Leaving HIGH is the SLK falling edge: capture MISO, present the next bit.
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            SLK      <= 1'b0;
            rx_shift <= rx_next;
            shift    <= shift_next;
            MOSI     <= shift_next[NBITS-1];
            bit_cnt  <= bit_cnt + 1'b1;
            state    <= S_LOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LOW: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= S_TRAIL;
            end else begin
              SLK   <= 1'b1;
              state <= S_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_TRAIL: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            CS      <= 1'b0;
            MOSI    <= 1'b0;
            done    <= owner ? 2'b10 : 2'b01;
            rx_data <= rx_shift;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench for spi_master_arb with CLK_DIV=2, NBITS=8.
module tb_spi_master_arb;
  import spi_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int NBITS   = 8;
  localparam int CS_LEN  = (2 * NBITS + 2) * CLK_DIV;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req = 2'b00;
  logic [NBITS-1:0] tx_data0 = '0;
  logic [NBITS-1:0] tx_data1 = '0;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic [NBITS-1:0] rx_data;
  logic             busy;
  logic             SLK;
  logic             CS;
  logic             MOSI;
  logic             MISO;
  state_t           state;
  int               miso_mode = 0;

  int n_cmp = 0;
  int n_err = 0;

  spi_master_arb #(.CLK_DIV(CLK_DIV), .NBITS(NBITS)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .tx_data0 (tx_data0),
    .tx_data1 (tx_data1),
    .gnt      (gnt),
    .done     (done),
    .rx_data  (rx_data),
    .busy     (busy),
    .SLK      (SLK),
    .CS       (CS),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .state    (state)
  );

  assign MISO = (miso_mode == 2) ? MOSI : (miso_mode == 1);

  // clock / reset
  always #5 clk = ~clk;

  // bus monitor: sampled on the falling clk edge, away from DUT updates
  int   cyc = 0;
  int   cs_cnt = 0;
  int   low_run = 0;
  int   cs_fall_cyc = -1;
  int   rise_cnt = 0;
  int   gnt_cnt = 0;
  int   done_cnt = 0;
  logic prev_cs = 1'b0;
  logic prev_slk = 1'b0;
  logic had_xfer = 1'b0;
  logic [31:0] cs_len_q[$];
  logic [31:0] gap_q[$];
  logic        mosi_q[$];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      cs_cnt   = 0;
      low_run  = 0;
      prev_cs  = 1'b0;
      prev_slk = 1'b0;
      had_xfer = 1'b0;
    end else begin
      if (gnt != 2'b00) gnt_cnt = gnt_cnt + 1;
      if (done != 2'b00) done_cnt = done_cnt + 1;
      if (SLK && !prev_slk) begin
        mosi_q.push_back(MOSI);
        rise_cnt = rise_cnt + 1;
      end
      if (CS) begin
        if (!prev_cs && had_xfer) gap_q.push_back(32'(low_run));
        cs_cnt = cs_cnt + 1;
      end else begin
        if (prev_cs) begin
          cs_len_q.push_back(32'(cs_cnt));
          cs_fall_cyc = cyc;
          cs_cnt      = 0;
          low_run     = 0;
          had_xfer    = 1'b1;
        end
        low_run = low_run + 1;
      end
      prev_cs  = CS;
      prev_slk = SLK;
    end
  end

  // scoreboard
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_gnt(input string tag, input logic [1:0] exp);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) break;
    end
    check({tag, "_gnt"}, 32'(gnt), 32'(exp));
    check({tag, "_busy_at_gnt"}, 32'(busy), 32'd1);
    #1;
    mosi_q.delete();
    cs_len_q.delete();
    rise_cnt = 0;
  endtask

  task automatic wait_done(input string tag, input logic [1:0] exp, input logic [NBITS-1:0] exp_rx);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done != 2'b00) break;
    end
    check({tag, "_done"}, 32'(done), 32'(exp));
    check({tag, "_rx"}, 32'(rx_data), 32'(exp_rx));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    #1;
    check({tag, "_cs_len"}, (cs_len_q.size() > 0) ? cs_len_q[0] : 32'd0, 32'(CS_LEN));
    check({tag, "_done_first_cs_low"}, 32'(cs_fall_cyc), 32'(cyc));
    cs_len_q.delete();
  endtask

  task automatic check_mosi(input string tag, input logic [NBITS-1:0] exp_word);
    logic [NBITS-1:0] got;
    got = '0;
    check({tag, "_rises"}, 32'(mosi_q.size()), 32'(NBITS));
    foreach (mosi_q[i]) if (i < NBITS) got[NBITS-1-i] = mosi_q[i];
    check({tag, "_mosi"}, 32'(got), 32'(exp_word));
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int g0;
  int d0;

  initial begin
    // reset state
    do_reset();
    @(negedge clk);
    check("rst_cs", 32'(CS), 32'd0);
    check("rst_slk", 32'(SLK), 32'd0);
    check("rst_mosi", 32'(MOSI), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx", 32'(rx_data), 32'd0);
    check("rst_state", 32'(state), 32'(S_IDLE));

    // single transfer from requester 0, MISO tied low
    @(posedge clk); #1;
    miso_mode = 0;
    tx_data0  = 8'hA5;
    req       = 2'b01;
    wait_gnt("a5", 2'b01);
    req = 2'b00;
    wait_done("a5", 2'b01, 8'h00);
    check_mosi("a5", 8'hA5);
    idle_cycles(1);
    check("a5_busy_after", 32'(busy), 32'd0);

    // requester 1 with MISO looped back
    miso_mode = 2;
    tx_data1  = 8'h3C;
    req       = 2'b10;
    wait_gnt("loop", 2'b10);
    req = 2'b00;
    wait_done("loop", 2'b10, 8'h3C);
    check_mosi("loop", 8'h3C);

    // MISO tied high
    idle_cycles(2);
    miso_mode = 1;
    tx_data1  = 8'h12;
    req       = 2'b10;
    wait_gnt("ones", 2'b10);
    req = 2'b00;
    wait_done("ones", 2'b10, 8'hFF);
    check_mosi("ones", 8'h12);
    idle_cycles(10);
    check("rx_held", 32'(rx_data), 32'hFF);

    // round robin with both requests held from reset
    do_reset();
    gap_q.delete();
    miso_mode = 0;
    tx_data0  = 8'h81;
    tx_data1  = 8'h7E;
    req       = 2'b11;
    wait_gnt("rr1", 2'b01);
    wait_done("rr1", 2'b01, 8'h00);
    check_mosi("rr1", 8'h81);
    wait_gnt("rr2", 2'b10);
    wait_done("rr2", 2'b10, 8'h00);
    check_mosi("rr2", 8'h7E);
    wait_gnt("rr3", 2'b01);
    @(posedge clk); #1;
    req = 2'b00;
    wait_done("rr3", 2'b01, 8'h00);
    check("rr_gap_count", 32'(gap_q.size()), 32'd2);
    check("rr_gap0_min2", 32'(gap_q.size() > 0 && gap_q[0] >= 2), 32'd1);
    check("rr_gap1_min2", 32'(gap_q.size() > 1 && gap_q[1] >= 2), 32'd1);

    // reset at the 4th SLK rise aborts the transfer
    idle_cycles(2);
    miso_mode = 0;
    tx_data0  = 8'hFF;
    req       = 2'b01;
    wait_gnt("abort", 2'b01);
    req = 2'b00;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (rise_cnt >= 4) break;
    end
    check("abort_rise4", 32'(rise_cnt), 32'd4);
    check("abort_cs_before", 32'(CS), 32'd1);
    d0  = done_cnt;
    rst = 1'b1;
    #1;
    check("abort_cs", 32'(CS), 32'd0);
    check("abort_slk", 32'(SLK), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(50);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    // clean transfer after the abort
    miso_mode = 2;
    tx_data1  = 8'h5A;
    req       = 2'b10;
    wait_gnt("post", 2'b10);
    req = 2'b00;
    wait_done("post", 2'b10, 8'h5A);
    check_mosi("post", 8'h5A);

    // req[0] raised while busy, dropped before it could be granted
    idle_cycles(2);
    miso_mode = 0;
    tx_data1  = 8'hC3;
    req       = 2'b10;
    wait_gnt("drop", 2'b10);
    req = 2'b01;
    wait_done("drop", 2'b10, 8'h00);
    req = 2'b00;
    g0  = gnt_cnt;
    idle_cycles(20);
    check("drop_no_gnt", 32'(gnt_cnt - g0), 32'd0);
    check("drop_cs_low", 32'(CS), 32'd0);
    check("drop_idle", 32'(state), 32'(S_IDLE));

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
